// File: rtl/fp_pkg.sv
// Shared constants and types for the pipelined floating-point adder/subtractor.
// The default widths give IEEE-754 single precision.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam int BIAS    = 2 ** (FP_EXP_W - 1) - 1;
    localparam int EXP_MAX = 2 ** FP_EXP_W - 1;

    // Bit positions inside out_flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam logic [FP_EXP_W+FP_MAN_W:0] QNAN =
        {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Control part of every stage register; the datapath fields sit beside it
    // because their widths follow the module parameters.
    typedef struct packed {
        logic      valid;
        fp_class_t cls;
        logic      sign;
        logic      eff_sub;
    } stage_ctl_t;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns W.
module fp_lzc #(
    parameter int W  = 28,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round)
// with FTZ, round-to-nearest-even, special values, status flags and back-pressure.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MAN_W  = FP_MAN_W,
    parameter bit RND_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_sum,
    output logic [3:0]             out_flags
);

    localparam int DW  = 1 + EXP_W + MAN_W;
    localparam int AW  = MAN_W + 4;
    localparam int SW  = MAN_W + 5;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(SW + 1);

    localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
    localparam logic signed [EW-1:0]    EXP_ALL_S = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0]    ONE_S     = EW'(1);
    localparam logic [DW-1:0]           QNAN_P    =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    // Handshake: all stages move together whenever the output slot is free
    // or being consumed; with advance low every register holds its value.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ---------------- S1: classify, swap, align ----------------
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               za, zb, ia, ib, na, nb;
    logic               swap;
    logic [MAN_W:0]     sig_a, sig_b, sig_l, sig_s;
    logic [EXP_W-1:0]   el, es, diff;
    logic               sl;
    logic [AW-1:0]      ext_s, aligned;
    logic               sticky;
    fp_class_t          cls_c;
    logic               csign;

    assign sa = in_a[DW-1];
    assign ea = in_a[DW-2:MAN_W];
    assign ma = in_a[MAN_W-1:0];
    assign sb = in_b[DW-1] ^ in_sub;
    assign eb = in_b[DW-2:MAN_W];
    assign mb = in_b[MAN_W-1:0];

    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (ea == EXP_ONES) && (ma == '0);
    assign ib = (eb == EXP_ONES) && (mb == '0);
    assign na = (ea == EXP_ONES) && (ma != '0);
    assign nb = (eb == EXP_ONES) && (mb != '0);

    assign sig_a = za ? '0 : {1'b1, ma};
    assign sig_b = zb ? '0 : {1'b1, mb};
    assign swap  = {eb, mb} > {ea, ma};
    assign sig_l = swap ? sig_b : sig_a;
    assign sig_s = swap ? sig_a : sig_b;
    assign el    = swap ? eb : ea;
    assign es    = swap ? ea : eb;
    assign sl    = swap ? sb : sa;
    assign diff  = el - es;
    assign ext_s = {sig_s, 3'b000};

    always_comb begin
        sticky  = 1'b0;
        aligned = '0;
        if (int'(diff) >= AW - 1) begin
            sticky  = |sig_s;
            aligned = {{(AW - 1){1'b0}}, sticky};
        end else begin
            sticky  = |(ext_s & ~({AW{1'b1}} << diff));
            aligned = (ext_s >> diff) | {{(AW - 1){1'b0}}, sticky};
        end
    end

    always_comb begin
        cls_c = NORM;
        csign = sl;
        if (na || nb) begin
            cls_c = NAN;
        end else if (ia && ib && (sa != sb)) begin
            cls_c = NAN;
        end else if (ia) begin
            cls_c = INF;
            csign = sa;
        end else if (ib) begin
            cls_c = INF;
            csign = sb;
        end else if (za && zb) begin
            // -0 survives only when both effective signs are negative
            cls_c = ZERO;
            csign = sa && sb;
        end
    end

    stage_ctl_t         s1_ctl;
    logic [EXP_W-1:0]   s1_exp;
    logic [AW-1:0]      s1_big, s1_small;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ctl   <= '0;
            s1_exp   <= '0;
            s1_big   <= '0;
            s1_small <= '0;
        end else if (advance) begin
            s1_ctl   <= '{valid: in_valid, cls: cls_c, sign: csign, eff_sub: sa ^ sb};
            s1_exp   <= el;
            s1_big   <= {sig_l, 3'b000};
            s1_small <= aligned;
        end
    end

    // ---------------- S2: magnitude add/subtract ----------------
    logic [SW-1:0]      sum_c;
    stage_ctl_t         s2_ctl;
    logic [EXP_W-1:0]   s2_exp;
    logic [SW-1:0]      s2_sum;

    // |big| >= |small| so the difference never goes negative
    assign sum_c = s1_ctl.eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                                  : ({1'b0, s1_big} + {1'b0, s1_small});

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_ctl <= '0;
            s2_exp <= '0;
            s2_sum <= '0;
        end else if (advance) begin
            s2_ctl <= s1_ctl;
            s2_exp <= s1_exp;
            s2_sum <= sum_c;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0]         lz;
    logic [AW-1:0]          norm;
    logic signed [EW-1:0]   exp_base, exp_n, exp_r;
    logic [MAN_W:0]         m;
    logic                   g, r, st, inc, inexact;
    logic [MAN_W+1:0]       mr;
    logic [MAN_W-1:0]       man_f;
    logic [DW-1:0]          res;
    logic [3:0]             flg;

    fp_lzc #(.W(SW), .CW(LZW)) u_lzc (
        .value (s2_sum),
        .count (lz)
    );

    assign exp_base = $signed({2'b00, s2_exp});

    always_comb begin
        if (s2_sum[SW-1]) begin
            norm  = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
            exp_n = exp_base + ONE_S;
        end else begin
            // lz >= 1 here; shifting by lz-1 puts the leading one at the hidden position
            norm  = s2_sum[AW-1:0] << (lz - LZW'(1));
            exp_n = exp_base - $signed(EW'(lz)) + ONE_S;
        end
    end

    assign m       = norm[AW-1:3];
    assign g       = norm[2];
    assign r       = norm[1];
    assign st      = norm[0];
    assign inexact = g || r || st;
    assign inc     = RND_EN && g && (r || st || m[0]);
    assign mr      = {1'b0, m} + (MAN_W + 2)'(inc);
    assign man_f   = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    assign exp_r   = mr[MAN_W+1] ? exp_n + ONE_S : exp_n;

    always_comb begin
        res = '0;
        flg = '0;
        case (s2_ctl.cls)
            NAN: begin
                res               = QNAN_P;
                flg[FLAG_INVALID] = 1'b1;
            end
            INF:  res = {s2_ctl.sign, EXP_ONES, {MAN_W{1'b0}}};
            ZERO: res = {s2_ctl.sign, {(DW - 1){1'b0}}};
            default: begin
                if (s2_sum == '0) begin
                    res = '0;
                end else if (exp_r >= EXP_ALL_S) begin
                    res                 = {s2_ctl.sign, EXP_ONES, {MAN_W{1'b0}}};
                    flg[FLAG_OVERFLOW]  = 1'b1;
                    flg[FLAG_INEXACT]   = 1'b1;
                end else if (exp_r[EW-1] || (exp_r == '0)) begin
                    res                 = {s2_ctl.sign, {(DW - 1){1'b0}}};
                    flg[FLAG_UNDERFLOW] = 1'b1;
                    flg[FLAG_INEXACT]   = 1'b1;
                end else begin
                    res               = {s2_ctl.sign, exp_r[EXP_W-1:0], man_f};
                    flg[FLAG_INEXACT] = inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_flags <= '0;
        end else if (advance) begin
            out_valid <= s2_ctl.valid;
            if (s2_ctl.valid) begin
                out_sum   <= res;
                out_flags <= flg;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe at single precision: arithmetic vectors,
// back-pressure ordering/stability and reset of in-flight operations.
`timescale 1ns/1ps
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [3:0]  out_flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic [35:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs [16] = '{
        '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},
        '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},
        '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 4'b0000},
        '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000},
        '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000},
        '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},
        '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001},
        '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001},
        '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001},
        '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011},
        '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},
        '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000},
        '{32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 4'b0000}
    };

    logic [31:0] bp_a [5] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] bp_b [5] = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic        bp_s [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] bp_e [5] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h40800000, 32'h40000000};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_flags (out_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; presents one op and measures latency.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] es, input logic [3:0] ef);
        int lat;
        check({tag, "_in_ready"}, in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_flags"}, out_flags, ef);
        @(posedge clk);
        #1;
    endtask

    task automatic backpressure();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic accepted;
        logic have_held = 1'b0;
        logic full_checked = 1'b0;
        logic [35:0] held = '0;
        logic [35:0] e;
        exp_q.delete();
        while (got < 5 && cyc < 60) begin
            out_ready = (cyc >= 6);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                in_a   = bp_a[sent];
                in_b   = bp_b[sent];
                in_sub = bp_s[sent];
            end
            #1;
            if (sent == 3 && !out_ready && !full_checked) begin
                check("bp_in_ready_low", in_ready, 0);
                full_checked = 1'b1;
            end
            if (out_valid && !out_ready) begin
                if (have_held) begin
                    check("bp_stable", {out_flags, out_sum}, held);
                end else begin
                    held      = {out_flags, out_sum};
                    have_held = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bp_result", {out_flags, out_sum}, e);
                end
                got++;
            end
            accepted = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (accepted) begin
                exp_q.push_back({4'b0000, bp_e[sent]});
                sent++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_got_count", got, 5);
        check("bp_sent_count", sent, 5);
        check("bp_queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_duplicate", out_valid, 0);
    endtask

    task automatic reset_in_flight();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'h3F800000;
        in_b      = 32'h40000000;
        in_sub    = 1'b0;
        @(posedge clk);
        #1;
        in_a = 32'h40000000;
        in_b = 32'h40000000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_out_valid_c%0d", k), out_valid, 0);
            if (k < 2) begin
                @(posedge clk);
                #1;
            end
        end
        run_op("rst_fresh", 32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_out_flags", out_flags, 0);
        check("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].f);
        end

        backpressure();
        reset_in_flight();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
